// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, default
// timing and well-known command bytes.
package ps2_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StInhibit,
      StRts,
      StData,
      StStop,
      StAck,
      StWaitIdle,
      StDone,
      StErr
   } ps2_tx_state_e;

   localparam int unsigned INHIBIT_CYCLES_DEF       = 5000;
   localparam int unsigned START_TIMEOUT_CYCLES_DEF = 750000;
   localparam int unsigned FRAME_TIMEOUT_CYCLES_DEF = 100000;
   localparam int unsigned IDLE_TIMEOUT_CYCLES_DEF  = 50000;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock. Shared with the receive side.
module ps2_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_sync_o,
   output logic dat_sync_o,
   output logic clk_fall_o
);

   logic clk_meta_q, clk_meta_d;
   logic clk_sync_q, clk_sync_d;
   logic clk_prev_q, clk_prev_d;
   logic dat_meta_q, dat_meta_d;
   logic dat_sync_q, dat_sync_d;

   always_comb begin
      clk_meta_d = ps2_clk_i;
      clk_sync_d = clk_meta_q;
      clk_prev_d = clk_sync_q;
      dat_meta_d = ps2_dat_i;
      dat_sync_d = dat_meta_q;
   end

   // Idle bus level is high, so reset to 1 to avoid a spurious falling edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= clk_meta_d;
         clk_sync_q <= clk_sync_d;
         clk_prev_q <= clk_prev_d;
         dat_meta_q <= dat_meta_d;
         dat_sync_q <= dat_sync_d;
      end
   end

   assign clk_sync_o = clk_sync_q;
   assign dat_sync_o = dat_sync_q;
   assign clk_fall_o = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends one byte with
// odd parity on device-generated clock edges and checks the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES       = INHIBIT_CYCLES_DEF,
   parameter int unsigned START_TIMEOUT_CYCLES = START_TIMEOUT_CYCLES_DEF,
   parameter int unsigned FRAME_TIMEOUT_CYCLES = FRAME_TIMEOUT_CYCLES_DEF,
   parameter int unsigned IDLE_TIMEOUT_CYCLES  = IDLE_TIMEOUT_CYCLES_DEF
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic       send_cmd,
   input  logic [7:0] cmd,
   output logic       busy,
   output logic       cmd_sent,
   output logic       tx_error,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);

   localparam int unsigned TimerMax =
      max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES, IDLE_TIMEOUT_CYCLES);
   localparam int unsigned TimerW   = $clog2(TimerMax + 1);
   localparam int unsigned FrameW   = $clog2(FRAME_TIMEOUT_CYCLES + 1);

   localparam logic [TimerW-1:0] InhibitLast = TimerW'(INHIBIT_CYCLES - 1);
   localparam logic [TimerW-1:0] StartLast   = TimerW'(START_TIMEOUT_CYCLES - 1);
   localparam logic [TimerW-1:0] IdleLast    = TimerW'(IDLE_TIMEOUT_CYCLES - 1);
   localparam logic [FrameW-1:0] FrameLast   = FrameW'(FRAME_TIMEOUT_CYCLES - 1);

   ps2_tx_state_e     state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [FrameW-1:0] frame_q, frame_d;
   logic [8:0]        shift_q, shift_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic              tx_bit_q, tx_bit_d;

   logic clk_sync, dat_sync, clk_fall;
   logic clk_low, dat_low;

   ps2_line_sync u_line_sync (
      .clk_i      (CLOCK_50),
      .rst_i      (Reset),
      .ps2_clk_i  (PS2_CLK),
      .ps2_dat_i  (PS2_DAT),
      .clk_sync_o (clk_sync),
      .dat_sync_o (dat_sync),
      .clk_fall_o (clk_fall)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      frame_d   = frame_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_bit_d  = tx_bit_q;
      clk_low   = 1'b0;
      dat_low   = 1'b0;
      cmd_sent  = 1'b0;
      tx_error  = 1'b0;
      busy      = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (send_cmd) begin
               shift_d   = {odd_parity(cmd), cmd};
               timer_d   = '0;
               bit_cnt_d = '0;
               state_d   = StInhibit;
            end
         end
         StInhibit: begin
            clk_low = 1'b1;
            if (timer_q == InhibitLast) begin
               dat_low = 1'b1;
               timer_d = '0;
               state_d = StRts;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StRts: begin
            dat_low = 1'b1;
            if (clk_fall) begin
               tx_bit_d  = shift_q[0];
               shift_d   = {1'b1, shift_q[8:1]};
               bit_cnt_d = 4'd1;
               frame_d   = '0;
               state_d   = StData;
            end else if (timer_q == StartLast) begin
               state_d = StErr;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StData: begin
            dat_low = ~tx_bit_q;
            frame_d = frame_q + 1'b1;
            if (frame_q == FrameLast) begin
               state_d = StErr;
            end else if (clk_fall) begin
               tx_bit_d  = shift_q[0];
               shift_d   = {1'b1, shift_q[8:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               // Edge 9 carries the parity bit, the last bit the host drives.
               if (bit_cnt_q == 4'd8) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            dat_low = ~tx_bit_q;
            frame_d = frame_q + 1'b1;
            if (frame_q == FrameLast) begin
               state_d = StErr;
            end else if (clk_fall) begin
               tx_bit_d = 1'b1;
               state_d  = StAck;
            end
         end
         StAck: begin
            frame_d = frame_q + 1'b1;
            if (frame_q == FrameLast) begin
               state_d = StErr;
            end else if (clk_fall) begin
               if (!dat_sync) begin
                  timer_d = '0;
                  state_d = StWaitIdle;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StWaitIdle: begin
            if (clk_sync && dat_sync) begin
               state_d = StDone;
            end else if (timer_q == IdleLast) begin
               state_d = StErr;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StDone: begin
            cmd_sent  = 1'b1;
            timer_d   = '0;
            frame_d   = '0;
            bit_cnt_d = '0;
            tx_bit_d  = 1'b1;
            state_d   = StIdle;
         end
         StErr: begin
            tx_error  = 1'b1;
            timer_d   = '0;
            frame_d   = '0;
            bit_cnt_d = '0;
            tx_bit_d  = 1'b1;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         frame_q   <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_bit_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         frame_q   <= frame_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_bit_q  <= tx_bit_d;
      end
   end

   // Open-drain: only ever pull low or release.
   assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a cycle-based PS/2 device model and
// scaled-down timing parameters.
module tb_ps2_host_tx;

   localparam int unsigned INH   = 50;
   localparam int unsigned START = 600;
   localparam int unsigned FRAME = 1500;
   localparam int unsigned IDLE  = 400;
   localparam int          H     = 20;  // device clock half-period in system cycles

   logic       CLOCK_50 = 1'b0;
   logic       Reset    = 1'b1;
   logic       send_cmd = 1'b0;
   logic [7:0] cmd      = 8'h00;
   logic       busy, cmd_sent, tx_error;
   wire        ps2_clk, ps2_dat;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   pullup (ps2_clk);
   pullup (ps2_dat);
   assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

   ps2_host_tx #(
      .INHIBIT_CYCLES       (INH),
      .START_TIMEOUT_CYCLES (START),
      .FRAME_TIMEOUT_CYCLES (FRAME),
      .IDLE_TIMEOUT_CYCLES  (IDLE)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .Reset    (Reset),
      .send_cmd (send_cmd),
      .cmd      (cmd),
      .busy     (busy),
      .cmd_sent (cmd_sent),
      .tx_error (tx_error),
      .PS2_CLK  (ps2_clk),
      .PS2_DAT  (ps2_dat)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_fail   = 0;
   int sent_cnt = 0;
   int err_cnt  = 0;
   int tcount   = 0;

   always @(negedge CLOCK_50) begin
      if (cmd_sent === 1'b1) sent_cnt <= sent_cnt + 1;
      if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
   end

   typedef struct {
      logic [7:0] c;
      logic [8:0] exp_bits;  // {parity, data}
      bit         ack;
      int         exp_sent;
      int         exp_err;
      string      name;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      tcount++;
   endtask

   // Request a send and follow the inhibit phase up to RTS entry.
   task automatic start_send(input logic [7:0] c);
      int n;
      send_cmd = 1'b1;
      cmd      = c;
      tick();
      send_cmd = 1'b0;
      cmd      = 8'h00;
      check("busy_on_accept", 32'(busy), 32'd1);
      n = 0;
      while (ps2_clk === 1'b0 && n < int'(INH) + 20) begin
         n++;
         tick();
      end
      check("inhibit_len", n, INH);
      check("start_bit", 32'(ps2_dat), 32'd0);
   endtask

   // Device model: clocks n_edges falling edges, samples data before each rise.
   task automatic dev_clock(input int n_edges, input bit do_ack, input int inject_edge,
                            output logic [9:0] got, output int t1);
      got = '0;
      t1  = 0;
      repeat (10) tick();
      for (int e = 1; e <= n_edges; e++) begin
         if (e == 1) t1 = tcount;
         dev_clk_low = 1'b1;
         if (e == inject_edge) begin
            send_cmd = 1'b1;
            cmd      = 8'h12;
         end
         repeat (H) tick();
         if (e == inject_edge) begin
            check("busy_during_data", 32'(busy), 32'd1);
            send_cmd = 1'b0;
         end
         if (e <= 10) got[e-1] = ps2_dat;
         dev_clk_low = 1'b0;
         if (e == 10 && do_ack) dev_dat_low = 1'b1;
         if (e == 11) dev_dat_low = 1'b0;
         repeat (H) tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] got;
      int         t1, s0, e0, r;

      vecs[0] = '{8'hED, 9'h1ED, 1'b1, 1, 0, "set_leds"};
      vecs[1] = '{8'h01, 9'h001, 1'b1, 1, 0, "par_0x01"};
      vecs[2] = '{8'h00, 9'h100, 1'b1, 1, 0, "par_0x00"};
      vecs[3] = '{8'hFF, 9'h1FF, 1'b1, 1, 0, "par_0xff"};
      vecs[4] = '{8'hED, 9'h1ED, 1'b0, 0, 1, "no_ack"};

      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_sent", 32'(cmd_sent), 32'd0);
      check("rst_tx_error", 32'(tx_error), 32'd0);
      check("rst_clk_line", 32'(ps2_clk), 32'd1);
      check("rst_dat_line", 32'(ps2_dat), 32'd1);
      Reset = 1'b0;
      repeat (2) tick();

      for (int i = 0; i < 5; i++) begin
         s0 = sent_cnt;
         e0 = err_cnt;
         start_send(vecs[i].c);
         dev_clock(11, vecs[i].ack, 0, got, t1);
         repeat (10) tick();
         check({vecs[i].name, "_bits"}, 32'(got[8:0]), 32'(vecs[i].exp_bits));
         check({vecs[i].name, "_stop"}, 32'(got[9]), 32'd1);
         check({vecs[i].name, "_sent"}, sent_cnt - s0, vecs[i].exp_sent);
         check({vecs[i].name, "_err"}, err_cnt - e0, vecs[i].exp_err);
         check({vecs[i].name, "_busy_end"}, 32'(busy), 32'd0);
         check({vecs[i].name, "_lines_end"}, 32'({ps2_clk, ps2_dat}), 32'b11);
      end

      // No device: error exactly START cycles after RTS entry.
      s0 = sent_cnt;
      e0 = err_cnt;
      start_send(8'hF4);
      r = 0;
      while (tx_error !== 1'b1 && r < int'(START) + 50) begin
         tick();
         r++;
      end
      check("start_timeout_cycles", r, START);
      check("start_timeout_lines", 32'({ps2_clk, ps2_dat}), 32'b11);
      repeat (5) tick();
      check("start_timeout_err", err_cnt - e0, 1);
      check("start_timeout_sent", sent_cnt - s0, 0);
      check("start_timeout_busy", 32'(busy), 32'd0);

      // Stall after edge 5: frame timer expires; +3 = sync, edge detect, state reg.
      s0 = sent_cnt;
      e0 = err_cnt;
      start_send(8'hED);
      dev_clock(5, 1'b1, 0, got, t1);
      while (tx_error !== 1'b1 && tcount < t1 + int'(FRAME) + 50) tick();
      check("frame_timeout_cycles", tcount - t1, FRAME + 3);
      repeat (5) tick();
      check("frame_timeout_err", err_cnt - e0, 1);
      check("frame_timeout_sent", sent_cnt - s0, 0);
      check("frame_timeout_lines", 32'({ps2_clk, ps2_dat}), 32'b11);

      // send_cmd with 0x12 during DATA is ignored.
      s0 = sent_cnt;
      e0 = err_cnt;
      start_send(8'hED);
      dev_clock(11, 1'b1, 3, got, t1);
      repeat (20) tick();
      check("busy_ign_bits", 32'(got[8:0]), 32'h1ED);
      check("busy_ign_sent", sent_cnt - s0, 1);
      check("busy_ign_err", err_cnt - e0, 0);
      check("busy_ign_no_restart", 32'(ps2_clk), 32'd1);

      // Reset during DATA while bit 1 (= 0) is being driven.
      start_send(8'hED);
      dev_clock(2, 1'b1, 0, got, t1);
      check("pre_reset_dat", 32'(ps2_dat), 32'd0);
      s0 = sent_cnt;
      e0 = err_cnt;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("reset_dat_released", 32'(ps2_dat), 32'd1);
      check("reset_clk_released", 32'(ps2_clk), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      repeat (FRAME + 50) tick();
      check("reset_no_sent", sent_cnt - s0, 0);
      check("reset_no_err", err_cnt - e0, 0);

      // Normal send after reset.
      s0 = sent_cnt;
      e0 = err_cnt;
      start_send(8'hF4);
      dev_clock(11, 1'b1, 0, got, t1);
      repeat (10) tick();
      check("enable_bits", 32'(got[8:0]), 32'h0F4);
      check("enable_sent", sent_cnt - s0, 1);
      check("enable_err", err_cnt - e0, 0);
      check("enable_busy_end", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
